// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, feeding the ALU.
// Holds the decoded instruction for one cycle, resolves RAW hazards from
// EX/MEM and MEM/WB, and raises a load-use hazard that inserts one bubble.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    exm_rd,
  input  logic                     exm_reg_write,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic [REG_ADDR_W-1:0]    mwb_rd,
  input  logic                     mwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    mwb_wdata,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     load_use_hazard
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  // Registered copies of the ID fields that only feed the operand muxes
  logic [REG_ADDR_W-1:0]    ex_rs1_r;
  logic [REG_ADDR_W-1:0]    ex_rs2_r;
  logic [DATA_WIDTH-1:0]    ex_rs1_data_r;
  logic [DATA_WIDTH-1:0]    ex_rs2_data_r;
  logic [DATA_WIDTH-1:0]    ex_imm_r;
  logic                     ex_alu_src_r;

  logic                     load_use_hazard_s;
  logic                     load_bubble_s;
  logic [DATA_WIDTH-1:0]    fwd_a_s;
  logic [DATA_WIDTH-1:0]    fwd_b_s;
  logic [DATA_WIDTH-1:0]    src_b_s;

  // Forwarding select for one operand: EX/MEM wins over MEM/WB, x0 is never
  // forwarded, and a bubble in EX never picks up a forwarded value.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic                  valid,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [DATA_WIDTH-1:0] reg_data,
    input logic [REG_ADDR_W-1:0] e_rd,
    input logic                  e_we,
    input logic [DATA_WIDTH-1:0] e_data,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic                  w_we,
    input logic [DATA_WIDTH-1:0] w_data
  );
    logic [DATA_WIDTH-1:0] res;
    if (valid && e_we && (e_rd != REG_ZERO) && (e_rd == rs)) begin
      res = e_data;
    end else if (valid && w_we && (w_rd != REG_ZERO) && (w_rd == rs)) begin
      res = w_data;
    end else begin
      res = reg_data;
    end
    return res;
  endfunction

  // Load in EX whose destination is read by the instruction sitting in ID
  always_comb begin
    load_use_hazard_s = 1'b0;
    if (ex_valid && ex_mem_read && (ex_rd != REG_ZERO) && id_valid) begin
      if ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd))) begin
        load_use_hazard_s = 1'b1;
      end else begin
        load_use_hazard_s = 1'b0;
      end
    end else begin
      load_use_hazard_s = 1'b0;
    end
  end

  // Bubble is loaded on flush (even under stall), or on an unstalled hazard / empty ID
  always_comb begin
    load_bubble_s = 1'b0;
    if (flush) begin
      load_bubble_s = 1'b1;
    end else if (!stall && (load_use_hazard_s || !id_valid)) begin
      load_bubble_s = 1'b1;
    end else begin
      load_bubble_s = 1'b0;
    end
  end

  // ID/EX register: clear, bubble, hold on stall, or capture from ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_rd         <= REG_ZERO;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_pc         <= DATA_ZERO;
      Operation     <= {OPCODE_LENGTH{1'b0}};
      ex_rs1_r      <= REG_ZERO;
      ex_rs2_r      <= REG_ZERO;
      ex_rs1_data_r <= DATA_ZERO;
      ex_rs2_data_r <= DATA_ZERO;
      ex_imm_r      <= DATA_ZERO;
      ex_alu_src_r  <= 1'b0;
    end else if (load_bubble_s) begin
      ex_valid      <= 1'b0;
      ex_rd         <= REG_ZERO;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_pc         <= DATA_ZERO;
      Operation     <= {OPCODE_LENGTH{1'b0}};
      ex_rs1_r      <= REG_ZERO;
      ex_rs2_r      <= REG_ZERO;
      ex_rs1_data_r <= DATA_ZERO;
      ex_rs2_data_r <= DATA_ZERO;
      ex_imm_r      <= DATA_ZERO;
      ex_alu_src_r  <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_rd         <= id_rd;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_pc         <= id_pc;
      Operation     <= id_alu_op;
      ex_rs1_r      <= id_rs1;
      ex_rs2_r      <= id_rs2;
      ex_rs1_data_r <= id_rs1_data;
      ex_rs2_data_r <= id_rs2_data;
      ex_imm_r      <= id_imm;
      ex_alu_src_r  <= id_alu_src;
    end else begin
      ex_valid      <= ex_valid;
      ex_rd         <= ex_rd;
      ex_reg_write  <= ex_reg_write;
      ex_mem_read   <= ex_mem_read;
      ex_mem_write  <= ex_mem_write;
      ex_pc         <= ex_pc;
      Operation     <= Operation;
      ex_rs1_r      <= ex_rs1_r;
      ex_rs2_r      <= ex_rs2_r;
      ex_rs1_data_r <= ex_rs1_data_r;
      ex_rs2_data_r <= ex_rs2_data_r;
      ex_imm_r      <= ex_imm_r;
      ex_alu_src_r  <= ex_alu_src_r;
    end
  end

  // Zero-latency forwarding of both source operands
  always_comb begin
    fwd_a_s = fwd_sel(ex_valid, ex_rs1_r, ex_rs1_data_r, exm_rd, exm_reg_write,
                      exm_result, mwb_rd, mwb_reg_write, mwb_wdata);
    fwd_b_s = fwd_sel(ex_valid, ex_rs2_r, ex_rs2_data_r, exm_rd, exm_reg_write,
                      exm_result, mwb_rd, mwb_reg_write, mwb_wdata);
  end

  // SrcB takes the immediate for I-type; the store path always sees rs2
  always_comb begin
    src_b_s = fwd_b_s;
    if (ex_alu_src_r) begin
      src_b_s = ex_imm_r;
    end else begin
      src_b_s = fwd_b_s;
    end
  end

  assign SrcA            = fwd_a_s;
  assign SrcB            = src_b_s;
  assign ex_store_data   = fwd_b_s;
  assign load_use_hazard = load_use_hazard_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_uses_rs1, id_uses_rs2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_reg_write, mwb_reg_write;
  logic [31:0] exm_result, mwb_wdata;
  logic [31:0] SrcA, SrcB, ex_pc, ex_store_data;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [4:0]  ex_rd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [3:0]  op;
    logic        v;
  } exp_t;
  exp_t sb[$];

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_wdata(mwb_wdata),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] st, input logic [3:0] op, input logic v);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.st = st; e.op = op; e.v = v;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".SrcA"}, SrcA, e.a);
      chk({e.tag, ".SrcB"}, SrcB, e.b);
      chk({e.tag, ".store"}, ex_store_data, e.st);
      chk({e.tag, ".Operation"}, {28'd0, Operation}, {28'd0, e.op});
      chk({e.tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, e.v});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] op,
                        input logic src, input logic u1, input logic u2,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    id_alu_op = op; id_alu_src = src; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic [4:0] erd, input logic ewe, input logic [31:0] ed,
                         input logic [4:0] wrd, input logic wwe, input logic [31:0] wd);
    exm_rd = erd; exm_reg_write = ewe; exm_result = ed;
    mwb_rd = wrd; mwb_reg_write = wwe; mwb_wdata = wd;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    #2;
    push("reset", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    pop_check();
    chk("reset.hazard", {31'd0, load_use_hazard}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Plain capture
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 32'h100, 4'b0010,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push("plain", 32'd5, 32'd7, 32'd7, 4'b0010, 1'b1);
    tick();
    pop_check();
    chk("plain.ex_pc", ex_pc, 32'h100);
    chk("plain.ex_rd", {27'd0, ex_rd}, 32'd5);

    // Forward priority
    set_id(1'b1, 5'd3, 5'd0, 5'd6, 32'h11, 32'h22, 32'd0, 32'h104, 4'b0000,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_fwd(5'd3, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB);
    push("fwd_exm", 32'hAA, 32'h22, 32'h22, 4'b0000, 1'b1);
    #1;
    pop_check();
    exm_reg_write = 1'b0;
    push("fwd_mwb", 32'hBB, 32'h22, 32'h22, 4'b0000, 1'b1);
    #1;
    pop_check();
    set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h33, 32'h22, 32'd0, 32'h108, 4'b0000,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_fwd(5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB);
    push("fwd_x0", 32'h33, 32'h22, 32'h22, 4'b0000, 1'b1);
    #1;
    pop_check();
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

    // Load-use: lw x4 in EX, add reads x4 in ID
    set_id(1'b1, 5'd1, 5'd0, 5'd4, 32'h1000, 32'd0, 32'd8, 32'h10C, 4'b0000,
           1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd4, 5'd7, 32'h50, 32'hDEAD, 32'd0, 32'h110, 4'b0000,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu.hazard", {31'd0, load_use_hazard}, 32'd1);
    push("lu.lw", 32'h1000, 32'd8, 32'd0, 4'b0000, 1'b1);
    pop_check();
    push("lu.bubble", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();
    pop_check();
    chk("lu.hazard_clear", {31'd0, load_use_hazard}, 32'd0);
    set_fwd(5'd0, 1'b0, 32'd0, 5'd4, 1'b1, 32'h44);
    push("lu.add", 32'h50, 32'h44, 32'h44, 4'b0000, 1'b1);
    tick();
    pop_check();

    // flush and stall together load a bubble
    flush = 1'b1; stall = 1'b1;
    push("flush_stall", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();
    pop_check();
    flush = 1'b0; stall = 1'b0;
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    set_id(1'b1, 5'd8, 5'd9, 5'd10, 32'h123, 32'h456, 32'd0, 32'h114, 4'b0110,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push("pre_stall", 32'h123, 32'h456, 32'h456, 4'b0110, 1'b1);
    tick();
    pop_check();
    stall = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 5'd11, 32'hFFF, 32'hEEE, 32'd0, 32'h118, 4'b1111,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push("stall_hold", 32'h123, 32'h456, 32'h456, 4'b0110, 1'b1);
      tick();
      pop_check();
    end
    stall = 1'b0;

    // Immediate path with forwarded store data
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h77, 32'h99, 32'hFFFF_FFFC, 32'h11C, 4'b0000,
           1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_fwd(5'd2, 1'b1, 32'h10, 5'd0, 1'b0, 32'd0);
    push("imm", 32'h77, 32'hFFFF_FFFC, 32'h10, 4'b0000, 1'b1);
    #1;
    pop_check();
    chk("imm.mem_write", {31'd0, ex_mem_write}, 32'd1);

    // id_valid=0 captures a bubble with control bits cleared
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    set_id(1'b0, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'd0, 32'h120, 4'b0111,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    push("idle", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();
    pop_check();
    chk("idle.reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("idle.mem_read", {31'd0, ex_mem_read}, 32'd0);
    chk("idle.ex_rd", {27'd0, ex_rd}, 32'd0);

    // Async reset in the middle of a stall
    set_id(1'b1, 5'd1, 5'd0, 5'd3, 32'h5A5A, 32'd0, 32'd0, 32'h124, 4'b0011,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    set_fwd(5'd1, 1'b1, 32'hCC, 5'd0, 1'b0, 32'd0);
    push("pre_rst", 32'hCC, 32'd0, 32'd0, 4'b0011, 1'b1);
    #1;
    pop_check();
    #2;
    rst_n = 1'b0;
    #1;
    push("mid_rst", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    pop_check();
    tick();
    rst_n = 1'b1; stall = 1'b0;
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    set_id(1'b1, 5'd2, 5'd0, 5'd3, 32'h600D, 32'd0, 32'd0, 32'h128, 4'b0101,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    push("post_rst", 32'h600D, 32'd0, 32'd0, 4'b0101, 1'b1);
    tick();
    pop_check();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
